pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 16-bit pipelined MIPS core.
- Drives enable/flush controls for the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles reset-release pipeline fill, load-use stalls, taken-branch flushes and data-memory wait freezes.
- State advances on rising clk; outputs settle within the cycle so pipeline registers capturing on falling clk see stable controls.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX / EX/MEM enables and flushes.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int REG_W             = 3,
  parameter int INIT_CYCLES       = 3,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [1:0]       ctrl_state,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  // state    | meaning
  // INIT     | bubble-fill after reset release
  // RUN      | normal issue
  // LU_STALL | extra load-use bubbles beyond the first
  // MEM_WAIT | frozen on dmem_busy; resumes as ret_q
  localparam logic [1:0] S_INIT     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_LU_STALL = 2'd2;
  localparam logic [1:0] S_MEM_WAIT = 2'd3;

  typedef enum logic [2:0] {O_INIT, O_FREEZE, O_BRFL, O_STALL, O_NORM} out_sel_t;

  logic [1:0] state_q, state_d;
  logic [1:0] ret_q, ret_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] eff_state;
  logic       lu;
  out_sel_t   out_sel;

  assign lu = idex_mem_read && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  // Leaving MEM_WAIT acts as the return state within the same cycle.
  assign eff_state = ((state_q == S_MEM_WAIT) && !dmem_busy) ? ret_q : state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ret_q   <= S_RUN;
      cnt_q   <= 4'(INIT_CYCLES);
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    case (eff_state)
      S_INIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RUN;
      end
      S_RUN: begin
        if (dmem_busy) begin
          ret_d   = S_RUN;
          state_d = S_MEM_WAIT;
        end else if (branch_taken) begin
          state_d = S_RUN;
        end else if (lu && (LOAD_STALL_CYCLES > 1)) begin
          state_d = S_LU_STALL;
          cnt_d   = 4'(LOAD_STALL_CYCLES - 1);
        end else begin
          state_d = S_RUN;
        end
      end
      S_LU_STALL: begin
        if (dmem_busy) begin
          ret_d   = S_LU_STALL;
          state_d = S_MEM_WAIT;
        end else if (branch_taken) begin
          state_d = S_RUN;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q <= 4'd1) ? S_RUN : S_LU_STALL;
        end
      end
      default: state_d = S_MEM_WAIT;
    endcase
  end

  always_comb begin
    out_sel = O_NORM;
    case (eff_state)
      S_INIT:     out_sel = O_INIT;
      S_RUN:      out_sel = dmem_busy    ? O_FREEZE :
                            branch_taken ? O_BRFL   :
                            lu           ? O_STALL  : O_NORM;
      S_LU_STALL: out_sel = dmem_busy    ? O_FREEZE :
                            branch_taken ? O_BRFL   : O_STALL;
      default:    out_sel = O_FREEZE;
    endcase
  end

  always_comb begin
    {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en} = 6'b110101;
    case (out_sel)
      O_INIT:   {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en} = 6'b011111;
      O_FREEZE: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en} = 6'b000000;
      O_BRFL:   {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en} = 6'b111111;
      O_STALL:  {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en} = 6'b000111;
      default:  {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en} = 6'b110101;
    endcase
  end

  assign ctrl_state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Saturating; only reset clears them.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != S_INIT) && !pc_en && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if ((out_sel == O_BRFL) && (flush_cnt_q != 16'hFFFF))
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (LOAD_STALL_CYCLES=1 and 2) share stimulus.
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] V_INIT = 6'b011111;
  localparam logic [5:0] V_FRZ  = 6'b000000;
  localparam logic [5:0] V_BRFL = 6'b111111;
  localparam logic [5:0] V_STL  = 6'b000111;
  localparam logic [5:0] V_NORM = 6'b110101;

  logic       clk;
  logic       rst_n;
  logic [2:0] ifid_rs, ifid_rt, idex_rt;
  logic       ifid_uses_rt, idex_mem_read, branch_taken, dmem_busy;

  logic        pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_en1;
  logic [1:0]  state1;
  logic [15:0] scnt1, fcnt1;
  logic        pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2, exmem_en2;
  logic [1:0]  state2;
  logic [15:0] scnt2, fcnt2;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.REG_W(3), .INIT_CYCLES(3), .LOAD_STALL_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1), .idex_en(idex_en1),
    .idex_flush(idex_flush1), .exmem_en(exmem_en1), .ctrl_state(state1),
    .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  pipe_hazard_ctrl #(.REG_W(3), .INIT_CYCLES(3), .LOAD_STALL_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_en(pc_en2), .ifid_en(ifid_en2), .ifid_flush(ifid_flush2), .idex_en(idex_en2),
    .idex_flush(idex_flush2), .exmem_en(exmem_en2), .ctrl_state(state2),
    .stall_cnt(scnt2), .flush_cnt(fcnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [5:0] o1, input logic [1:0] s1,
                    input logic [5:0] o2, input logic [1:0] s2);
    chk({tag, "/out1"},   16'({pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_en1}), 16'(o1));
    chk({tag, "/state1"}, 16'(state1), 16'(s1));
    chk({tag, "/out2"},   16'({pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2, exmem_en2}), 16'(o2));
    chk({tag, "/state2"}, 16'(state2), 16'(s2));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic init_seq(input string tag);
    dmem_busy    = 1'b1;
    branch_taken = 1'b1;
    #2 st({tag, "_c1"}, V_INIT, 2'd0, V_INIT, 2'd0);
    cyc();
    #2 st({tag, "_c2"}, V_INIT, 2'd0, V_INIT, 2'd0);
    cyc();
    dmem_busy    = 1'b0;
    branch_taken = 1'b0;
    #2 st({tag, "_c3"}, V_INIT, 2'd0, V_INIT, 2'd0);
    cyc();
    #2 st({tag, "_run"}, V_NORM, 2'd1, V_NORM, 2'd1);
    cyc();
  endtask

  logic [15:0] exp_s1, exp_s2, exp_f;

  initial begin
    rst_n = 1'b1;
    ifid_rs = '0; ifid_rt = '0; idex_rt = '0;
    ifid_uses_rt = 1'b0; idex_mem_read = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
    #2 rst_n = 1'b0;
    #2 st("reset", V_INIT, 2'd0, V_INIT, 2'd0);
    chk("reset/scnt1", scnt1, 16'd0);
    chk("reset/fcnt1", fcnt1, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_seq("init");

    idex_mem_read = 1'b1; idex_rt = 3'd3; ifid_rs = 3'd3;
    #2 st("lu_rs", V_STL, 2'd1, V_STL, 2'd1);
    cyc();

    idex_mem_read = 1'b0; dmem_busy = 1'b1;
    #2 st("frz1", V_FRZ, 2'd1, V_FRZ, 2'd2);
    cyc();
    #2 st("frz2", V_FRZ, 2'd3, V_FRZ, 2'd3);
    cyc();
    #2 st("frz3", V_FRZ, 2'd3, V_FRZ, 2'd3);
    cyc();
    #2 st("frz4", V_FRZ, 2'd3, V_FRZ, 2'd3);
    cyc();
    dmem_busy = 1'b0;
    #2 st("resume", V_NORM, 2'd3, V_STL, 2'd3);
    cyc();
    #2 st("run1", V_NORM, 2'd1, V_NORM, 2'd1);
    cyc();

    branch_taken = 1'b1; idex_mem_read = 1'b1; idex_rt = 3'd2; ifid_rt = 3'd2;
    ifid_uses_rt = 1'b1; ifid_rs = 3'd0;
    #2 st("br_lu", V_BRFL, 2'd1, V_BRFL, 2'd1);
    cyc();
    branch_taken = 1'b0; idex_rt = 3'd0; ifid_rs = 3'd0; ifid_rt = 3'd0;
    #2 st("rt_zero", V_NORM, 2'd1, V_NORM, 2'd1);
    cyc();
    idex_rt = 3'd5; ifid_rt = 3'd5; ifid_uses_rt = 1'b0; ifid_rs = 3'd1;
    #2 st("rt_unused", V_NORM, 2'd1, V_NORM, 2'd1);
    cyc();
    ifid_uses_rt = 1'b1;
    #2 st("lu_rt", V_STL, 2'd1, V_STL, 2'd1);
    cyc();
    idex_mem_read = 1'b0; branch_taken = 1'b1;
    #2 st("br_abort", V_BRFL, 2'd1, V_BRFL, 2'd2);
    cyc();
    branch_taken = 1'b0;
    #2 st("post_br", V_NORM, 2'd1, V_NORM, 2'd1);
`ifdef HAZ_PERF_CNT_EN
    exp_s1 = 16'd6; exp_s2 = 16'd7; exp_f = 16'd2;
`else
    exp_s1 = 16'd0; exp_s2 = 16'd0; exp_f = 16'd0;
`endif
    chk("perf/scnt1", scnt1, exp_s1);
    chk("perf/fcnt1", fcnt1, exp_f);
    chk("perf/scnt2", scnt2, exp_s2);
    chk("perf/fcnt2", fcnt2, exp_f);
    cyc();

    idex_mem_read = 1'b1; idex_rt = 3'd4; ifid_rs = 3'd4; ifid_uses_rt = 1'b0;
    #2 st("lu_j", V_STL, 2'd1, V_STL, 2'd1);
    cyc();
    idex_mem_read = 1'b0;
    #2 st("lu_hold", V_NORM, 2'd1, V_STL, 2'd2);
    rst_n = 1'b0;
    #2 st("rst_mid", V_INIT, 2'd0, V_INIT, 2'd0);
    chk("rst_mid/scnt2", scnt2, 16'd0);
    chk("rst_mid/fcnt2", fcnt2, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_seq("reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
